// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with occupancy count, almost-full/almost-empty thresholds,
// registered or first-word-fall-through read data, synchronous flush and sticky error flags.
module sync_fifo_ctrl #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] wdata,
    input  logic             wr_en,
    output logic             full,
    output logic             almost_full,
    output logic [WIDTH-1:0] rdata,
    input  logic             rd_en,
    output logic             empty,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    input  logic             flush,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_afull;
    logic             r_aempty;
    logic             r_ovf;
    logic             r_udf;

    logic             w_wr_acc;
    logic             w_rd_acc;
    logic             w_ovf_set;
    logic             w_udf_set;
    logic [CW-1:0]    w_count_nxt;
    logic [PW-1:0]    w_wptr_nxt;
    logic [PW-1:0]    w_rptr_nxt;

    // Explicit wrap so non-power-of-two depths never touch unused entries.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == PTR_LAST) begin
            return {PW{1'b0}};
        end else begin
            return ptr + PW'(1'b1);
        end
    endfunction

    // Request qualification and next-state for pointers and occupancy.
    always_comb begin
        w_wr_acc    = wr_en && !r_full  && !flush;
        w_rd_acc    = rd_en && !r_empty && !flush;
        w_ovf_set   = wr_en && r_full   && !flush;
        w_udf_set   = rd_en && r_empty  && !flush;
        w_count_nxt = r_count;
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        if (flush) begin
            w_count_nxt = {CW{1'b0}};
            w_wptr_nxt  = {PW{1'b0}};
            w_rptr_nxt  = {PW{1'b0}};
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   w_count_nxt = r_count + CW'(1'b1);
                2'b01:   w_count_nxt = r_count - CW'(1'b1);
                default: w_count_nxt = r_count;
            endcase
            if (w_wr_acc) begin
                w_wptr_nxt = ptr_inc(r_wptr);
            end else begin
                w_wptr_nxt = r_wptr;
            end
            if (w_rd_acc) begin
                w_rptr_nxt = ptr_inc(r_rptr);
            end else begin
                w_rptr_nxt = r_rptr;
            end
        end
    end

    // Pointers, occupancy and status flags; flags are decoded from the next count so they
    // change only on clock edges and track the registered count exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr   <= {PW{1'b0}};
            r_rptr   <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            r_wptr   <= w_wptr_nxt;
            r_rptr   <= w_rptr_nxt;
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == CNT_MAX);
            r_empty  <= (w_count_nxt == {CW{1'b0}});
            r_afull  <= (w_count_nxt >= AF_CNT);
            r_aempty <= (w_count_nxt <= AE_CNT);
        end
    end

    // Sticky error flags; a new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (clr_err) begin
                r_ovf <= 1'b0;
            end
            if (w_udf_set) begin
                r_udf <= 1'b1;
            end else if (clr_err) begin
                r_udf <= 1'b0;
            end
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; forced to zero while nothing is stored.
            always_comb begin
                if (r_empty) begin
                    rdata = {WIDTH{1'b0}};
                end else begin
                    rdata = r_mem[r_rptr];
                end
            end
        end else begin : g_reg_read
            logic [WIDTH-1:0] r_rdata;

            // Output register loads the head word only on an accepted read.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rdata <= {WIDTH{1'b0}};
                end else if (w_rd_acc) begin
                    r_rdata <= r_mem[r_rptr];
                end
            end

            assign rdata = r_rdata;
        end
    endgenerate

    assign count        = r_count;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: two DEPTH=5 instances (registered and FWFT read)
// share one stimulus stream; read data is checked by a queue-based scoreboard monitor.
module tb_sync_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wdata;
    logic       wr_en;
    logic       rd_en;
    logic       flush;
    logic       clr_err;

    logic       full0, afull0, empty0, aempty0, ovf0, udf0;
    logic       full1, afull1, empty1, aempty1, ovf1, udf1;
    logic [7:0] rdata0, rdata1;
    logic [2:0] count0, count1;

    int         n_checks = 0;
    int         n_errs   = 0;
    logic [7:0] mq  [$];
    logic [7:0] sb0 [$];
    logic [7:0] sb1 [$];

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.WIDTH(8), .DEPTH(5), .FWFT(0), .AF_LEVEL(3), .AE_LEVEL(2)) u0 (
        .clk(clk), .rst_n(rst_n), .wdata(wdata), .wr_en(wr_en), .full(full0),
        .almost_full(afull0), .rdata(rdata0), .rd_en(rd_en), .empty(empty0),
        .almost_empty(aempty0), .count(count0), .flush(flush), .overflow(ovf0),
        .underflow(udf0), .clr_err(clr_err)
    );

    sync_fifo_ctrl #(.WIDTH(8), .DEPTH(5), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(2)) u1 (
        .clk(clk), .rst_n(rst_n), .wdata(wdata), .wr_en(wr_en), .full(full1),
        .almost_full(afull1), .rdata(rdata1), .rd_en(rd_en), .empty(empty1),
        .almost_empty(aempty1), .count(count1), .flush(flush), .overflow(ovf1),
        .underflow(udf1), .clr_err(clr_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Drive one cycle of requests; the reference queue decides acceptance from its own size.
    task automatic drv(input bit w, input logic [7:0] d, input bit r, input bit f, input bit ce);
        bit wacc;
        bit racc;
        logic [7:0] head;
        wr_en   = w;
        wdata   = d;
        rd_en   = r;
        flush   = f;
        clr_err = ce;
        racc = r && !f && (mq.size() != 0);
        wacc = w && !f && (mq.size() != 5);
        if (racc) begin
            head = mq.pop_front();
            sb0.push_back(head);
            sb1.push_back(head);
        end
        if (wacc) mq.push_back(d);
        if (f) mq.delete();
        cyc();
    endtask

    task automatic idle();
        drv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic st(input int c);
        chk("count0", count0, c);
        chk("empty0", empty0, c == 0);
        chk("full0", full0, c == 5);
        chk("afull0", afull0, c >= 3);
        chk("aempty0", aempty0, c <= 2);
        chk("count1", count1, c);
        chk("empty1", empty1, c == 0);
        chk("full1", full1, c == 5);
        chk("afull1", afull1, c >= 3);
        chk("aempty1", aempty1, c <= 2);
    endtask

    task automatic errs(input bit ov, input bit un);
        chk("ovf0", ovf0, ov);
        chk("udf0", udf0, un);
        chk("ovf1", ovf1, ov);
        chk("udf1", udf1, un);
    endtask

    // Scoreboard monitor: registered output is due one cycle after an accepted read,
    // the FWFT output is due while its read is being acknowledged.
    initial begin
        bit vld0 = 1'b0;
        forever begin
            @(negedge clk);
            if (vld0) begin
                if (sb0.size() == 0) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL rdata0_extra got %0h want none", rdata0);
                end else begin
                    chk("rdata0", rdata0, sb0.pop_front());
                end
            end
            vld0 = rst_n && rd_en && !empty0 && !flush;
            if (rst_n && rd_en && !empty1 && !flush) begin
                if (sb1.size() == 0) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL rdata1_extra got %0h want none", rdata1);
                end else begin
                    chk("rdata1", rdata1, sb1.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; wdata = 8'h00; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
        #12;
        st(0);
        errs(1'b0, 1'b0);
        chk("rst_rdata0", rdata0, 8'h00);
        chk("rst_rdata1", rdata1, 8'h00);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Fill 0x11..0x55 then drain in order.
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, 8'(17 * (i + 1)), 1'b0, 1'b0, 1'b0);
            st(i + 1);
        end
        for (int i = 0; i < 5; i++) begin
            drv(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            chk("seq_rdata0", rdata0, 17 * (i + 1));
            st(4 - i);
        end
        idle();
        chk("hold_rdata0", rdata0, 8'h55);
        chk("empty_rdata1", rdata1, 8'h00);

        // Sustained simultaneous write/read at occupancy 2 across many wraps.
        drv(1'b1, 8'h60, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            drv(1'b1, 8'(8'h62 + i), 1'b1, 1'b0, 1'b0);
            chk("wrap_count0", count0, 2);
            chk("wrap_count1", count1, 2);
        end
        drv(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        drv(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("wrap_last_rdata0", rdata0, 8'hC5);
        idle();
        st(0);
        errs(1'b0, 1'b0);

        // Overflow at full with both requests, then underflow at empty with both.
        for (int i = 0; i < 5; i++) drv(1'b1, 8'(8'h81 + i), 1'b0, 1'b0, 1'b0);
        st(5);
        drv(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        st(4);
        errs(1'b1, 1'b0);
        drv(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        errs(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drv(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        st(0);
        chk("ovf_drain_rdata0", rdata0, 8'h85);
        drv(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        st(1);
        errs(1'b0, 1'b1);
        drv(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        st(0);
        errs(1'b0, 1'b0);
        drv(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        errs(1'b0, 1'b1);
        drv(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        errs(1'b0, 1'b0);

        // FWFT presentation before any read request.
        drv(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("fwft_empty1", empty1, 1'b0);
        chk("fwft_rdata1", rdata1, 8'hA5);
        chk("reg_hold_rdata0", rdata0, 8'h3C);
        drv(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("fwft_empty_after", empty1, 1'b1);
        chk("fwft_rdata1_zero", rdata1, 8'h00);
        chk("reg_rdata0_a5", rdata0, 8'hA5);

        // Flush at count 3 with both requests asserted.
        drv(1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 8'h32, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        st(3);
        chk("pre_flush_rdata1", rdata1, 8'h31);
        drv(1'b1, 8'h44, 1'b1, 1'b1, 1'b0);
        st(0);
        errs(1'b0, 1'b0);
        chk("flush_hold_rdata0", rdata0, 8'hA5);
        chk("flush_rdata1", rdata1, 8'h00);
        drv(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        chk("post_flush_rdata1", rdata1, 8'h77);
        drv(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("post_flush_rdata0", rdata0, 8'h77);
        idle();

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 4; i++) drv(1'b1, 8'(8'h91 + i), 1'b0, 1'b0, 1'b0);
        st(4);
        wr_en = 1'b1;
        wdata = 8'hF0;
        rst_n = 1'b0;
        #1;
        st(0);
        errs(1'b0, 1'b0);
        chk("arst_rdata0", rdata0, 8'h00);
        chk("arst_rdata1", rdata1, 8'h00);
        mq.delete();
        wr_en = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drv(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        st(1);
        chk("post_rst_rdata1", rdata1, 8'h5A);
        drv(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("post_rst_rdata0", rdata0, 8'h5A);
        idle();
        st(0);

        chk("sb0_drained", sb0.size(), 0);
        chk("sb1_drained", sb1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
